// File: rtl/id_ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the decode/execute boundary:
//   - ALUOp encodings produced by the control unit
//   - major opcode constants decoded by the control unit
//   - packed control bundle carried from decode into execute
//   - helper that turns a raw decode bundle into the bundle held in EX
// ----------------------------------------------------------------------------
package id_ex_stage_pkg;

    typedef enum logic [1:0] {
        ALUOP_LOAD_STORE = 2'b00,
        ALUOP_BRANCH     = 2'b01,
        ALUOP_RTYPE      = 2'b10
    } alu_op_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    // alu_op is kept as a plain 2-bit field so an unused encoding from the
    // control unit travels through unchanged instead of needing a cast.
    typedef struct packed {
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

    // Bundle as held in EX: mem_to_reg is meaningless without reg_write, so it
    // is cleared to keep an undriven select from reaching writeback, and an
    // invalid slot never carries any asserted control bit.
    function automatic ctrl_t ctrl_gate(input logic valid, input ctrl_t c);
        ctrl_t r;
        r            = c;
        r.mem_to_reg = c.mem_to_reg & c.reg_write;
        if (!valid) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detector. Flags when the instruction in EX is
// a load whose destination is read by the instruction currently in decode.
// Ports:
//   ex_valid, ex_mem_read, ex_rd  - load candidate held in EX
//   id_valid, id_alu_src,
//   id_mem_write, id_rs1, id_rs2  - consumer candidate in decode
//   hazard                        - stall/bubble request
// ----------------------------------------------------------------------------
module hazard_detect #(
    parameter int RA_W = 5
) (
    input  logic            ex_valid,
    input  logic            ex_mem_read,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            id_valid,
    input  logic            id_alu_src,
    input  logic            id_mem_write,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    output logic            hazard
);

    logic use_rs1;
    logic use_rs2;
    logic ex_is_load;

    // rs2 is a real source for R-type (register operand) and for stores /
    // branches, where alu_src may select the immediate but rs2 is still read.
    assign use_rs1    = id_valid;
    assign use_rs2    = id_valid & (~id_alu_src | id_mem_write);
    // x0 is hard-wired, so a load to x0 never produces a dependency.
    assign ex_is_load = ex_valid & ex_mem_read & (ex_rd != '0);

    assign hazard = ex_is_load &
                    ((use_rs1 & (ex_rd == id_rs1)) |
                     (use_rs2 & (ex_rd == id_rs2)));

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection, flush handling and
// a saturating bubble counter.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   id_*              - decoded instruction: valid, control bits, PC,
//                       operands, immediate, register indices, funct bits
//   flush             - taken branch downstream; kill the decode slot
//   stall_o           - hold PC and IF/ID this cycle (combinational)
//   ex_*              - registered copy of the decode slot (or a bubble)
//   bubble_cnt        - bubbles inserted by hazard or flush since reset
// ----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [1:0]       id_alu_op,
    input  logic             id_branch,
    input  logic             id_mem_read,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [3:0]       id_funct,
    input  logic             flush,
    output logic             stall_o,
    output logic             ex_valid,
    output logic [1:0]       ex_alu_op,
    output logic             ex_branch,
    output logic             ex_mem_read,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_reg_write,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RA_W-1:0]  ex_rs1,
    output logic [RA_W-1:0]  ex_rs2,
    output logic [RA_W-1:0]  ex_rd,
    output logic [3:0]       ex_funct,
    output logic [CNT_W-1:0] bubble_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    ctrl_t            id_ctrl;
    ctrl_t            ctrl_p0;
    logic             vld_p0;
    logic [XLEN-1:0]  pc_p0;
    logic [XLEN-1:0]  rs1_data_p0;
    logic [XLEN-1:0]  rs2_data_p0;
    logic [XLEN-1:0]  imm_p0;
    logic [RA_W-1:0]  rs1_p0;
    logic [RA_W-1:0]  rs2_p0;
    logic [RA_W-1:0]  rd_p0;
    logic [3:0]       funct_p0;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             hazard;
    logic             bubble;

    assign id_ctrl = '{
        alu_op:     id_alu_op,
        branch:     id_branch,
        mem_read:   id_mem_read,
        mem_to_reg: id_mem_to_reg,
        mem_write:  id_mem_write,
        alu_src:    id_alu_src,
        reg_write:  id_reg_write
    };

    hazard_detect #(
        .RA_W (RA_W)
    ) u_hazard_detect (
        .ex_valid     (vld_p0),
        .ex_mem_read  (ctrl_p0.mem_read),
        .ex_rd        (rd_p0),
        .id_valid     (id_valid),
        .id_alu_src   (id_alu_src),
        .id_mem_write (id_mem_write),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .hazard       (hazard)
    );

    // A flush redirects the front end, so it must not also be held; a flush
    // that coincides with a hazard is a single bubble.
    assign stall_o = hazard & ~flush;
    assign bubble  = flush | hazard;

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0       <= 1'b0;
            ctrl_p0      <= '0;
            pc_p0        <= '0;
            rs1_data_p0  <= '0;
            rs2_data_p0  <= '0;
            imm_p0       <= '0;
            rs1_p0       <= '0;
            rs2_p0       <= '0;
            rd_p0        <= '0;
            funct_p0     <= '0;
            bubble_cnt_q <= '0;
        end else if (bubble) begin
            vld_p0       <= 1'b0;
            ctrl_p0      <= '0;
            pc_p0        <= '0;
            rs1_data_p0  <= '0;
            rs2_data_p0  <= '0;
            imm_p0       <= '0;
            rs1_p0       <= '0;
            rs2_p0       <= '0;
            rd_p0        <= '0;
            funct_p0     <= '0;
            bubble_cnt_q <= sat_inc(bubble_cnt_q);
        end else begin
            vld_p0       <= id_valid;
            ctrl_p0      <= ctrl_gate(id_valid, id_ctrl);
            pc_p0        <= id_pc;
            rs1_data_p0  <= id_rs1_data;
            rs2_data_p0  <= id_rs2_data;
            imm_p0       <= id_imm;
            rs1_p0       <= id_rs1;
            rs2_p0       <= id_rs2;
            rd_p0        <= id_rd;
            funct_p0     <= id_funct;
        end
    end

    assign ex_valid      = vld_p0;
    assign ex_alu_op     = ctrl_p0.alu_op;
    assign ex_branch     = ctrl_p0.branch;
    assign ex_mem_read   = ctrl_p0.mem_read;
    assign ex_mem_to_reg = ctrl_p0.mem_to_reg;
    assign ex_mem_write  = ctrl_p0.mem_write;
    assign ex_alu_src    = ctrl_p0.alu_src;
    assign ex_reg_write  = ctrl_p0.reg_write;
    assign ex_pc         = pc_p0;
    assign ex_rs1_data   = rs1_data_p0;
    assign ex_rs2_data   = rs2_data_p0;
    assign ex_imm        = imm_p0;
    assign ex_rs1        = rs1_p0;
    assign ex_rs2        = rs2_p0;
    assign ex_rd         = rd_p0;
    assign ex_funct      = funct_p0;
    assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int XLEN = 64;
    localparam int RA_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            id_valid;
    logic [1:0]      id_alu_op;
    logic            id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic [3:0]      id_funct;
    logic            flush;

    logic            stall_o, ex_valid;
    logic [1:0]      ex_alu_op;
    logic            ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0]      ex_funct;
    logic [15:0]     bubble_cnt;

    // narrow-counter instance outputs
    logic            s_stall, s_valid;
    logic [1:0]      s_alu_op;
    logic            s_br, s_mr, s_m2r, s_mw, s_as, s_rw;
    logic [XLEN-1:0] s_pc, s_a, s_b, s_imm;
    logic [RA_W-1:0] s_rs1, s_rs2, s_rd;
    logic [3:0]      s_funct;
    logic [1:0]      s_cnt;

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct), .flush(flush),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct), .flush(flush),
        .stall_o(s_stall), .ex_valid(s_valid), .ex_alu_op(s_alu_op),
        .ex_branch(s_br), .ex_mem_read(s_mr), .ex_mem_to_reg(s_m2r),
        .ex_mem_write(s_mw), .ex_alu_src(s_as), .ex_reg_write(s_rw),
        .ex_pc(s_pc), .ex_rs1_data(s_a), .ex_rs2_data(s_b), .ex_imm(s_imm),
        .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct(s_funct),
        .bubble_cnt(s_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the slot held in EX, kept as plain fields.
    // m_ctl = {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write}
    bit        m_known = 0;
    bit        m_valid;
    bit [1:0]  m_aluop;
    bit [5:0]  m_ctl;
    bit [63:0] m_pc, m_a, m_b, m_imm;
    bit [4:0]  m_rs1, m_rs2, m_rd;
    bit [3:0]  m_funct;
    int        m_cnt, m_cnt2;

    function automatic bit m_hazard();
        bit reads_rs2;
        reads_rs2 = id_valid && (!id_alu_src || id_mem_write);
        if (!(m_valid && m_ctl[4] && m_rd != 0)) return 1'b0;
        return (id_valid && m_rd == id_rs1) || (reads_rs2 && m_rd == id_rs2);
    endfunction

    task automatic m_clear_slot();
        m_valid = 0; m_aluop = 0; m_ctl = 0;
        m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_funct = 0;
    endtask

    task automatic check_outputs();
        chk("ex_valid",  64'(ex_valid), 64'(m_valid));
        chk("ex_alu_op", 64'(ex_alu_op), 64'(m_aluop));
        chk("ex_ctrl",   64'({ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write}), 64'(m_ctl));
        chk("ex_pc",     ex_pc, m_pc);
        chk("ex_rs1_data", ex_rs1_data, m_a);
        chk("ex_rs2_data", ex_rs2_data, m_b);
        chk("ex_imm",    ex_imm, m_imm);
        chk("ex_idx",    64'({ex_rs1, ex_rs2, ex_rd}), 64'({m_rs1, m_rs2, m_rd}));
        chk("ex_funct",  64'(ex_funct), 64'(m_funct));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
        chk("bubble_cnt_w2", 64'(s_cnt), 64'(m_cnt2));
    endtask

    // One clock: check combinational stall, advance DUT and model, check EX.
    task automatic cycle();
        bit hz;
        #1;
        hz = m_hazard();
        if (m_known) chk("stall_o", 64'(stall_o), 64'(hz && !flush));
        @(posedge clk);
        if (!rst_n) begin
            m_clear_slot();
            m_cnt = 0; m_cnt2 = 0; m_known = 1;
        end else if (flush || hz) begin
            m_clear_slot();
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else begin
            m_valid = id_valid;
            if (id_valid) begin
                m_aluop = id_alu_op;
                m_ctl   = {id_branch, id_mem_read, id_mem_to_reg && id_reg_write,
                           id_mem_write, id_alu_src, id_reg_write};
            end else begin
                m_aluop = 0; m_ctl = 0;
            end
            m_pc = id_pc; m_a = id_rs1_data; m_b = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_funct = id_funct;
        end
        #1;
        if (m_known) check_outputs();
    endtask

    task automatic set_id(input bit v, input bit [1:0] op, input bit [5:0] ctl,
                          input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] rd);
        id_valid = v; id_alu_op = op;
        {id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write} = ctl;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_pc = {$urandom, $urandom}; id_rs1_data = {$urandom, $urandom};
        id_rs2_data = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
        id_funct = 4'($urandom);
        flush = 1'b0;
    endtask

    task automatic set_random();
        set_id(($urandom_range(0, 7) != 0), 2'($urandom), 6'($urandom),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        flush = ($urandom_range(0, 7) == 0);
    endtask

    localparam bit [5:0] C_ADD  = 6'b000001;
    localparam bit [5:0] C_LW   = 6'b011011;
    localparam bit [5:0] C_ADDI = 6'b000011;
    localparam bit [5:0] C_SWX  = 6'b001110;

    int cnt_before;

    initial begin
        // reset with random inputs
        rst_n = 1'b0;
        set_random();
        cycle();
        set_random();
        cycle();
        chk("rst_valid", 64'(ex_valid), 64'd0);
        chk("rst_cnt", 64'(bubble_cnt), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        rst_n = 1'b1;

        // pass-through: add x5,x6,x7 at pc 0x40
        set_id(1, 2'b10, C_ADD, 6, 7, 5);
        id_pc = 64'h40;
        cycle();
        chk("pass_valid", 64'(ex_valid), 64'd1);
        chk("pass_alu_op", 64'(ex_alu_op), 64'd2);
        chk("pass_rd", 64'(ex_rd), 64'd5);
        chk("pass_pc", ex_pc, 64'h40);

        // load-use: lw x5 ; add x8,x5,x2
        set_id(1, 2'b00, C_LW, 1, 0, 5);
        cycle();
        set_id(1, 2'b10, C_ADD, 5, 2, 8);
        #1 chk("lu_stall", 64'(stall_o), 64'd1);
        cycle();
        chk("lu_bubble", 64'(ex_valid), 64'd0);
        chk("lu_cnt", 64'(bubble_cnt), 64'd1);
        chk("lu_restall", 64'(stall_o), 64'd0);
        cycle();
        chk("lu_capture", 64'(ex_valid), 64'd1);
        chk("lu_capture_rd", 64'(ex_rd), 64'd8);

        // lw x0 then consumer of x0
        set_id(1, 2'b00, C_LW, 1, 0, 0);
        cycle();
        set_id(1, 2'b10, C_ADD, 0, 0, 8);
        #1 chk("x0_stall", 64'(stall_o), 64'd0);
        cycle();

        // lw x5 then addi x9,x1 whose rs2 field is 5
        set_id(1, 2'b00, C_LW, 1, 0, 5);
        cycle();
        set_id(1, 2'b10, C_ADDI, 1, 5, 9);
        #1 chk("addi_stall", 64'(stall_o), 64'd0);
        cycle();

        // flush during a load-use hazard
        set_id(1, 2'b00, C_LW, 1, 0, 5);
        cycle();
        set_id(1, 2'b10, C_ADD, 5, 2, 8);
        flush = 1'b1;
        #1 chk("flush_stall", 64'(stall_o), 64'd0);
        cnt_before = int'(bubble_cnt);
        cycle();
        chk("flush_cnt", 64'(bubble_cnt), 64'(cnt_before + 1));
        chk("flush_bubble", 64'(ex_valid), 64'd0);

        // five flushes saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            set_id(1, 2'b10, C_ADD, 1, 2, 3);
            flush = 1'b1;
            cycle();
        end
        chk("sat_cnt_w2", 64'(s_cnt), 64'd3);

        // sw with mem_to_reg asserted
        set_id(1, 2'b00, C_SWX, 1, 2, 0);
        cycle();
        chk("sw_m2r", 64'(ex_mem_to_reg), 64'd0);
        chk("sw_mw", 64'(ex_mem_write), 64'd1);

        // randomized run, occasional reset
        for (int i = 0; i < 600; i++) begin
            set_random();
            rst_n = ($urandom_range(0, 59) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
